edge_event_arbiter: RTL
=======================

Name: edge_event_arbiter

Overview:
- Multi-channel rising-edge event collector with a round-robin scheduler. One posedge detector per input line latches events into pending bits.
- Pending events are granted one at a time into a single registered output slot. The slot uses a valid/ready handshake and carries the channel index.
- Sits between raw level/strobe inputs (buttons, status lines, other detectors) and a single shared event consumer. No event is dropped silently.

Parameters:
- N, 4, number of input channels; legal range 2..16. Index width CH_W = $clog2(N), derived internally, not overridable.

Ports:
- clk  input  1  clock, all logic on posedge
- rst  input  1  synchronous active-high reset
- a  input  N  raw input lines, one bit per channel, synchronous to clk
- ch_en  input  N  per-channel enable; a disabled channel creates no new events
- out_valid  output  1  output slot holds an event
- out_ch  output  CH_W  channel index of the held event
- out_ready  input  1  consumer accepts the held event when out_valid & out_ready
- pending_any  output  1  OR of all pending bits (excludes the output slot)
- ovf  output  N  per-channel sticky overflow flags
- ovf_clr  input  1  one-cycle pulse; clears all ovf bits

Behaviour:
- Reset (rst=1 at posedge) clears a_r, pending, ptr, out_valid, out_ch and ovf to 0. Reset wins over every other event in that cycle.
- Each channel keeps a_r[i] <= a[i] every cycle, regardless of ch_en.
- rise[i] = a[i] & ~a_r[i] & ch_en[i], combinational.
- A line held high through reset produces rise in the first cycle after reset, if enabled.
- Load condition: L = ~out_valid | out_ready, evaluated in the current cycle.
- Selection when L=1: scan the registered pending bits circularly, starting at ptr. Pick the first set bit, sel.
- Rises occurring in the same cycle are not visible to the scan.
- On the next edge when L=1 and a sel exists:
  - out_valid <= 1, out_ch <= sel
  - ptr <= (sel+1) mod N
  - pending[sel] cleared
- When L=1 and no bit is pending: out_valid <= 0; out_ch and ptr hold.
- When L=0 (out_valid=1, out_ready=0): out_valid, out_ch and ptr hold. This is back-to-back safe: a new grant can load in the same cycle as an accept, giving full throughput of 1 event/cycle.
- pending[i] next value = rise[i] | (pending[i] & ~(granted this edge & sel==i)).
  - A rise on the channel being granted in that same cycle re-sets pending. The new event is kept.
- Overflow: ovf[i] sets when rise[i] & pending[i] & ~(channel i granted this edge). In that case the event is merged and the loss is flagged.
  - An event held in the output slot does not count as pending, so a rise then is not an overflow.
  - ovf_clr clears all ovf bits; a same-cycle set wins over the clear for that bit.
- Deasserting ch_en[i] does not clear an existing pending[i]. It is still granted.
- Latency: a 0->1 on a[i] first seen at edge n (rise high in cycle n) sets pending at edge n+1 and out_valid at edge n+2, if the slot is free. Minimum 2 cycles from input edge to out_valid.
- Fairness: after channel k is granted, every other pending channel is granted before k again. Worst-case wait is N-1 grants.
- pending_any is combinational from the pending register.

Test Plan:
- Single event, N=4: reset, out_ready=1, pulse a[2] high for 1 cycle -> pending_any=1 one cycle later, then out_valid=1 with out_ch=2 for exactly 1 cycle; ovf=0.
- Simultaneous rises with round robin: a[0], a[1] and a[3] rise in the same cycle, out_ready=1 -> out_ch sequence 0,1,3 on consecutive cycles. Then a[0] and a[3] rise again (ptr=0) -> 0,3.
- Backpressure: out_ready=0, rise on ch1 then ch2 -> out_valid=1, out_ch=1 held stable for 5 cycles. Raise out_ready -> 1 accepted, then 2 next cycle, then out_valid=0.
- Overflow: out_ready=0, slot holds ch0. ch1 rises, falls, rises again while pending[1]=1 -> ovf=4'b0010. ovf_clr pulse -> ovf=0. Rise and ovf_clr in the same cycle -> ovf bit stays set.
- Grant/rise collision: ch2 pending and selected in the same cycle a[2] rises -> ch2 output, pending[2] remains 1, ch2 output again on a later grant, no ovf.
- Reset mid-operation and gating: with pending=4'b1010 and out_valid=1, assert rst -> all outputs 0 on the next cycle. a[3] held high through reset with ch_en[3]=1 -> one ch3 event after reset. With ch_en[3]=0 -> no event.

Source files
------------

// File: rtl/edge_event_arbiter.sv
// Rising-edge event collector: per-channel posedge detectors feed sticky pending
// bits, which a round-robin scheduler drains into one valid/ready output slot.
module edge_event_arbiter #(
  parameter int N = 4,
  localparam int CH_W = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    a,
  input  logic [N-1:0]    ch_en,
  output logic            out_valid,
  output logic [CH_W-1:0] out_ch,
  input  logic            out_ready,
  output logic            pending_any,
  output logic [N-1:0]    ovf,
  input  logic            ovf_clr
);

  logic [N-1:0]    a_r_q, a_r_d;
  logic [N-1:0]    pend_q, pend_d;
  logic [N-1:0]    ovf_q, ovf_d;
  logic [CH_W-1:0] ptr_q, ptr_d;
  logic            out_valid_q, out_valid_d;
  logic [CH_W-1:0] out_ch_q, out_ch_d;

  logic [N-1:0]    rise;
  logic [N-1:0]    gnt_oh;
  logic            load;
  logic            found;
  logic            grant;
  logic [CH_W-1:0] sel;
  logic [CH_W:0]   cand;

  assign load  = ~out_valid_q | out_ready;
  assign grant = load & found;

  // Circular scan of the registered pending bits, starting at ptr.
  // cand is one bit wider so ptr+k never wraps before the mod-N reduction.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    cand  = '0;
    for (int k = 0; k < N; k++) begin
      cand = {1'b0, ptr_q} + (CH_W + 1)'(k);
      if (cand >= (CH_W + 1)'(N)) begin
        cand = cand - (CH_W + 1)'(N);
      end
      if (!found && pend_q[cand[CH_W-1:0]]) begin
        found = 1'b1;
        sel   = cand[CH_W-1:0];
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_chan
      assign rise[gi]   = a[gi] & ~a_r_q[gi] & ch_en[gi];
      assign gnt_oh[gi] = grant & (sel == CH_W'(gi));
      // A rise on the channel being granted re-arms pending instead of overflowing.
      assign pend_d[gi] = rise[gi] | (pend_q[gi] & ~gnt_oh[gi]);
      assign ovf_d[gi]  = (rise[gi] & pend_q[gi] & ~gnt_oh[gi]) |
                          (ovf_q[gi] & ~ovf_clr);
    end
  endgenerate

  assign a_r_d = a;

  always_comb begin
    out_valid_d = out_valid_q;
    out_ch_d    = out_ch_q;
    ptr_d       = ptr_q;
    if (load) begin
      out_valid_d = found;
      if (found) begin
        out_ch_d = sel;
        ptr_d    = (sel == CH_W'(N - 1)) ? '0 : sel + CH_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_r_q       <= '0;
      pend_q      <= '0;
      ovf_q       <= '0;
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
    end else begin
      a_r_q       <= a_r_d;
      pend_q      <= pend_d;
      ovf_q       <= ovf_d;
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_ch_q    <= out_ch_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_ch      = out_ch_q;
  assign pending_any = |pend_q;
  assign ovf         = ovf_q;

endmodule
